// File: rtl/uart_fifo_transceiver_if.sv
// Host-side and pin-side signals of the FIFO-buffered UART transceiver.
// The slave modport is the transceiver; the master modport is the host or bench.
interface uart_fifo_transceiver_if #(
  parameter int unsigned CLOCK_DIVIDER_WIDTH = 16,
  parameter int unsigned DATA_WIDTH          = 8
);
  logic [CLOCK_DIVIDER_WIDTH-1:0] clock_divider_i;
  logic                           two_stop_bits_i;
  logic                           parity_bit_i;
  logic                           parity_even_i;
  logic                           write_i;
  logic [DATA_WIDTH-1:0]          data_i;
  logic                           tx_full_o;
  logic                           tx_empty_o;
  logic                           tx_busy_o;
  logic                           read_i;
  logic [DATA_WIDTH-1:0]          data_o;
  logic                           rx_empty_o;
  logic                           rx_full_o;
  logic                           clear_errors_i;
  logic                           parity_error_o;
  logic                           framing_error_o;
  logic                           overrun_o;
  logic                           serial_i;
  logic                           serial_o;

  modport master (
    output clock_divider_i, two_stop_bits_i, parity_bit_i, parity_even_i,
    output write_i, data_i, read_i, clear_errors_i, serial_i,
    input  tx_full_o, tx_empty_o, tx_busy_o, data_o, rx_empty_o, rx_full_o,
    input  parity_error_o, framing_error_o, overrun_o, serial_o
  );

  modport slave (
    input  clock_divider_i, two_stop_bits_i, parity_bit_i, parity_even_i,
    input  write_i, data_i, read_i, clear_errors_i, serial_i,
    output tx_full_o, tx_empty_o, tx_busy_o, data_o, rx_empty_o, rx_full_o,
    output parity_error_o, framing_error_o, overrun_o, serial_o
  );
endinterface

// File: rtl/uart_fifo_transceiver.sv
// UART transceiver with TX/RX FIFOs, serial input synchroniser, glitch-rejecting
// start detection and sticky parity/framing/overrun flags.
module uart_fifo_transceiver #(
  parameter int unsigned CLOCK_DIVIDER_WIDTH = 16,
  parameter int unsigned DATA_WIDTH          = 8,
  parameter int unsigned FIFO_DEPTH_LOG2     = 4
) (
  input logic                    clock_i,
  input logic                    reset_i,
  uart_fifo_transceiver_if.slave bus
);

  localparam int unsigned Depth = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned Cw    = CLOCK_DIVIDER_WIDTH;
  localparam int unsigned Aw    = FIFO_DEPTH_LOG2;
  localparam int unsigned BitW  = $clog2(DATA_WIDTH);

  typedef logic [Aw:0] ptr_t;

  logic [Cw-1:0] bit_period;
  assign bit_period = (bus.clock_divider_i < Cw'(4)) ? Cw'(4) : bus.clock_divider_i;

  // ---------------------------------------------------------------- TX FIFO
  logic [DATA_WIDTH-1:0] tx_mem [Depth];
  ptr_t                  tx_wptr_q, tx_rptr_q;
  logic                  tx_full, tx_empty, tx_push, tx_pop;
  logic [DATA_WIDTH-1:0] tx_head;

  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  assign tx_full  = (tx_wptr_q[Aw] != tx_rptr_q[Aw]) && (tx_wptr_q[Aw-1:0] == tx_rptr_q[Aw-1:0]);
  assign tx_push  = bus.write_i && !tx_full;
  assign tx_head  = tx_mem[tx_rptr_q[Aw-1:0]];

  always_ff @(posedge clock_i) begin
    if (tx_push) tx_mem[tx_wptr_q[Aw-1:0]] <= bus.data_i;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + ptr_t'(1);
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + ptr_t'(1);
    end
  end

  // ---------------------------------------------------------------- TX FSM
  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop1, TxStop2} tx_state_e;

  tx_state_e             tx_state_q;
  logic [Cw-1:0]         tx_cnt_q, tx_period_q;
  logic [DATA_WIDTH-1:0] tx_shift_q;
  logic [BitW-1:0]       tx_bit_q;
  logic                  tx_par_q, tx_par_en_q, tx_two_stop_q;
  logic                  serial_q, tx_busy_q;
  logic                  tx_bit_end, tx_frame_end;

  assign tx_bit_end   = (tx_cnt_q == '0);
  assign tx_frame_end = tx_bit_end && ((tx_state_q == TxStop2) ||
                                       ((tx_state_q == TxStop1) && !tx_two_stop_q));
  // The next frame is loaded either from idle or straight out of the last stop bit.
  assign tx_pop = !tx_empty && ((tx_state_q == TxIdle) || tx_frame_end);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      tx_state_q    <= TxIdle;
      tx_cnt_q      <= '0;
      tx_period_q   <= Cw'(4);
      tx_shift_q    <= '0;
      tx_bit_q      <= '0;
      tx_par_q      <= 1'b0;
      tx_par_en_q   <= 1'b0;
      tx_two_stop_q <= 1'b0;
      serial_q      <= 1'b1;
      tx_busy_q     <= 1'b0;
    end else if (tx_pop) begin
      tx_state_q    <= TxStart;
      tx_cnt_q      <= bit_period - Cw'(1);
      tx_period_q   <= bit_period;
      tx_shift_q    <= tx_head;
      tx_bit_q      <= '0;
      tx_par_q      <= (^tx_head) ^ ~bus.parity_even_i;
      tx_par_en_q   <= bus.parity_bit_i;
      tx_two_stop_q <= bus.two_stop_bits_i;
      serial_q      <= 1'b0;
      tx_busy_q     <= 1'b1;
    end else if (tx_state_q != TxIdle) begin
      if (!tx_bit_end) begin
        tx_cnt_q <= tx_cnt_q - Cw'(1);
      end else begin
        tx_cnt_q <= tx_period_q - Cw'(1);
        unique case (tx_state_q)
          TxStart: begin
            tx_state_q <= TxData;
            serial_q   <= tx_shift_q[0];
            tx_shift_q <= tx_shift_q >> 1;
          end
          TxData: begin
            if (tx_bit_q == BitW'(DATA_WIDTH - 1)) begin
              tx_state_q <= tx_par_en_q ? TxParity : TxStop1;
              serial_q   <= tx_par_en_q ? tx_par_q : 1'b1;
            end else begin
              tx_bit_q   <= tx_bit_q + BitW'(1);
              serial_q   <= tx_shift_q[0];
              tx_shift_q <= tx_shift_q >> 1;
            end
          end
          TxParity: begin
            tx_state_q <= TxStop1;
            serial_q   <= 1'b1;
          end
          TxStop1: begin
            if (tx_two_stop_q) begin
              tx_state_q <= TxStop2;
            end else begin
              tx_state_q <= TxIdle;
              tx_busy_q  <= 1'b0;
            end
          end
          default: begin
            tx_state_q <= TxIdle;
            tx_busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------- RX sync
  logic [1:0] sync_q;
  logic       rx_line;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], bus.serial_i};
  end
  assign rx_line = sync_q[1];

  // ---------------------------------------------------------------- RX FSM
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop, RxBreak} rx_state_e;

  rx_state_e             rx_state_q;
  logic [Cw-1:0]         rx_cnt_q, rx_period_q;
  logic [DATA_WIDTH-1:0] rx_shift_q;
  logic [BitW-1:0]       rx_bit_q;
  logic                  rx_par_q, rx_par_en_q, rx_par_even_q;
  logic                  rx_sample, rx_done, framing_set, parity_set;

  assign rx_sample   = (rx_cnt_q == '0);
  assign rx_done     = (rx_state_q == RxStop) && rx_sample;
  assign framing_set = rx_done && !rx_line;
  assign parity_set  = rx_done && rx_par_en_q &&
                       (rx_par_q != ((^rx_shift_q) ^ ~rx_par_even_q));

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rx_state_q    <= RxIdle;
      rx_cnt_q      <= '0;
      rx_period_q   <= Cw'(4);
      rx_shift_q    <= '0;
      rx_bit_q      <= '0;
      rx_par_q      <= 1'b0;
      rx_par_en_q   <= 1'b0;
      rx_par_even_q <= 1'b0;
    end else begin
      if (rx_state_q != RxIdle && rx_state_q != RxBreak && !rx_sample) begin
        rx_cnt_q <= rx_cnt_q - Cw'(1);
      end
      unique case (rx_state_q)
        RxIdle: begin
          if (!rx_line) begin
            rx_state_q    <= RxStart;
            rx_cnt_q      <= (bit_period >> 1) - Cw'(1);
            rx_period_q   <= bit_period;
            rx_par_en_q   <= bus.parity_bit_i;
            rx_par_even_q <= bus.parity_even_i;
          end
        end
        RxStart: begin
          if (rx_sample) begin
            // A line that is high again at mid start bit was only a glitch.
            rx_state_q <= rx_line ? RxIdle : RxData;
            rx_cnt_q   <= rx_period_q - Cw'(1);
            rx_bit_q   <= '0;
          end
        end
        RxData: begin
          if (rx_sample) begin
            rx_shift_q <= {rx_line, rx_shift_q[DATA_WIDTH-1:1]};
            rx_cnt_q   <= rx_period_q - Cw'(1);
            if (rx_bit_q == BitW'(DATA_WIDTH - 1)) begin
              rx_state_q <= rx_par_en_q ? RxParity : RxStop;
            end else begin
              rx_bit_q <= rx_bit_q + BitW'(1);
            end
          end
        end
        RxParity: begin
          if (rx_sample) begin
            rx_par_q   <= rx_line;
            rx_cnt_q   <= rx_period_q - Cw'(1);
            rx_state_q <= RxStop;
          end
        end
        RxStop: begin
          if (rx_sample) rx_state_q <= rx_line ? RxIdle : RxBreak;
        end
        default: begin
          // Hold off after a framing error until the line recovers.
          if (rx_line) rx_state_q <= RxIdle;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [DATA_WIDTH-1:0] rx_mem [Depth];
  ptr_t                  rx_wptr_q, rx_rptr_q, rx_count, rx_rptr_next;
  logic                  rx_full, rx_empty, rx_push, rx_pop, overrun_set;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  assign rx_empty     = (rx_wptr_q == rx_rptr_q);
  assign rx_full      = (rx_wptr_q[Aw] != rx_rptr_q[Aw]) && (rx_wptr_q[Aw-1:0] == rx_rptr_q[Aw-1:0]);
  assign rx_count     = rx_wptr_q - rx_rptr_q;
  assign rx_rptr_next = rx_rptr_q + ptr_t'(1);
  assign rx_pop       = bus.read_i && !rx_empty;
  assign rx_push      = rx_done && (!rx_full || bus.read_i);
  assign overrun_set  = rx_done && rx_full && !bus.read_i;

  always_ff @(posedge clock_i) begin
    if (rx_push) rx_mem[rx_wptr_q[Aw-1:0]] <= rx_shift_q;
  end

  // data_o is a registered copy of the head so it holds its value once drained.
  always_comb begin
    data_d = data_q;
    if (rx_pop) begin
      if (rx_count > ptr_t'(1)) data_d = rx_mem[rx_rptr_next[Aw-1:0]];
      else if (rx_push)         data_d = rx_shift_q;
    end else if (rx_empty && rx_push) begin
      data_d = rx_shift_q;
    end
  end

  logic parity_error_q, framing_error_q, overrun_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rx_wptr_q       <= '0;
      rx_rptr_q       <= '0;
      data_q          <= '0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      if (rx_push) rx_wptr_q <= rx_wptr_q + ptr_t'(1);
      if (rx_pop)  rx_rptr_q <= rx_rptr_next;
      data_q          <= data_d;
      parity_error_q  <= (parity_error_q && !bus.clear_errors_i) || parity_set;
      framing_error_q <= (framing_error_q && !bus.clear_errors_i) || framing_set;
      overrun_q       <= (overrun_q && !bus.clear_errors_i) || overrun_set;
    end
  end

  assign bus.serial_o        = serial_q;
  assign bus.tx_busy_o       = tx_busy_q;
  assign bus.tx_full_o       = tx_full;
  assign bus.tx_empty_o      = tx_empty;
  assign bus.data_o          = data_q;
  assign bus.rx_empty_o      = rx_empty;
  assign bus.rx_full_o       = rx_full;
  assign bus.parity_error_o  = parity_error_q;
  assign bus.framing_error_o = framing_error_q;
  assign bus.overrun_o       = overrun_q;

endmodule

// File: tb/tb_uart_fifo_transceiver.sv
// Directed bench for uart_fifo_transceiver: loopback frames, wire format, overrun,
// glitch/framing/parity errors, TX FIFO capacity and reset mid-frame.
module tb_uart_fifo_transceiver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_fifo_transceiver_if #(.CLOCK_DIVIDER_WIDTH(16), .DATA_WIDTH(8)) bus ();

  uart_fifo_transceiver #(
    .CLOCK_DIVIDER_WIDTH(16),
    .DATA_WIDTH         (8),
    .FIFO_DEPTH_LOG2    (4)
  ) dut (
    .clock_i(clk),
    .reset_i(rst),
    .bus    (bus)
  );

  logic loop_en = 1'b0;
  logic tb_line = 1'b1;
  assign bus.serial_i = loop_en ? bus.serial_o : tb_line;

  int   n_vec = 0;
  int   n_err = 0;
  logic line_rec [201];
  logic [7:0] exp1 [4] = '{8'h55, 8'hA3, 8'h00, 8'hFF};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d);
    bus.write_i = 1'b1;
    bus.data_i  = d;
    @(negedge clk);
    bus.write_i = 1'b0;
  endtask

  task automatic pop();
    bus.read_i = 1'b1;
    @(negedge clk);
    bus.read_i = 1'b0;
  endtask

  task automatic clear_errs();
    bus.clear_errors_i = 1'b1;
    @(negedge clk);
    bus.clear_errors_i = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int t = 0;
    while (bus.serial_o !== 1'b0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(t < 5000), 1);
  endtask

  task automatic wait_tx_done(input string tag);
    int t = 0;
    while (!(bus.tx_empty_o === 1'b1 && bus.tx_busy_o === 1'b0) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(t < 20000), 1);
  endtask

  task automatic wait_rx(input string tag);
    int t = 0;
    while (bus.rx_empty_o !== 1'b0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(t < 5000), 1);
  endtask

  // Bit-banged frame at 16 clocks per bit on tb_line.
  task automatic send_frame(input logic [7:0] d, input logic par_en, input logic par,
                            input logic stop);
    tb_line = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      tb_line = d[i];
      tick(16);
    end
    if (par_en) begin
      tb_line = par;
      tick(16);
    end
    tb_line = stop;
    tick(16);
    tb_line = 1'b1;
    tick(4);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cnt;
    int   ones;
    logic seen_low;
    logic [11:0] got_bits;

    bus.clock_divider_i = 16'd16;
    bus.two_stop_bits_i = 1'b0;
    bus.parity_bit_i    = 1'b0;
    bus.parity_even_i   = 1'b0;
    bus.write_i         = 1'b0;
    bus.data_i          = '0;
    bus.read_i          = 1'b0;
    bus.clear_errors_i  = 1'b0;
    tick(3);

    check("rst_serial", bus.serial_o, 1);
    check("rst_busy", bus.tx_busy_o, 0);
    check("rst_tx_empty", bus.tx_empty_o, 1);
    check("rst_rx_empty", bus.rx_empty_o, 1);
    check("rst_full", {bus.tx_full_o, bus.rx_full_o}, 0);
    check("rst_data", bus.data_o, 0);
    check("rst_flags", {bus.parity_error_o, bus.framing_error_o, bus.overrun_o}, 0);
    rst = 1'b0;
    tick(2);

    // 8N1 at 87 clocks per bit, looped back.
    bus.clock_divider_i = 16'd87;
    loop_en = 1'b1;
    tick(2);
    push(8'h55);
    wait_start("n1_start");
    cnt = 0;
    while (bus.serial_o === 1'b0 && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    check("n1_bit_time", cnt, 87);
    push(8'hA3);
    push(8'h00);
    push(8'hFF);
    wait_tx_done("n1_tx_done");
    tick(20);
    for (int i = 0; i < 4; i++) begin
      check("n1_rx_nonempty", bus.rx_empty_o, 0);
      check("n1_rx_data", bus.data_o, 32'(exp1[i]));
      pop();
    end
    check("n1_rx_drained", bus.rx_empty_o, 1);
    check("n1_flags", {bus.parity_error_o, bus.framing_error_o, bus.overrun_o}, 0);

    // 8E2 at 16 clocks per bit: record the wire for one frame plus next start.
    bus.clock_divider_i = 16'd16;
    bus.parity_bit_i    = 1'b1;
    bus.parity_even_i   = 1'b1;
    bus.two_stop_bits_i = 1'b1;
    tick(2);
    push(8'h07);
    push(8'h07);
    wait_start("e2_start");
    line_rec[0] = bus.serial_o;
    for (int j = 1; j < 201; j++) begin
      @(negedge clk);
      line_rec[j] = bus.serial_o;
    end
    for (int k = 0; k < 12; k++) got_bits[k] = line_rec[16*k + 8];
    check("e2_wire_bits", got_bits, 12'hE0E);
    ones = 0;
    for (int j = 144; j < 192; j++) ones += int'(line_rec[j]);
    check("e2_high_run", ones, 48);
    check("e2_next_start", line_rec[192], 0);
    wait_tx_done("e2_tx_done");
    tick(20);
    check("e2_rx_data0", bus.data_o, 8'h07);
    pop();
    check("e2_rx_data1", bus.data_o, 8'h07);
    pop();
    check("e2_flags", {bus.parity_error_o, bus.framing_error_o}, 0);

    // Overrun: 17 frames into a 16-deep RX FIFO with no reads.
    loop_en             = 1'b0;
    bus.parity_bit_i    = 1'b0;
    bus.two_stop_bits_i = 1'b0;
    tick(4);
    for (int i = 1; i <= 17; i++) begin
      send_frame(8'(8'h10 + i), 1'b0, 1'b0, 1'b1);
      if (i == 16) begin
        check("ovr_full16", bus.rx_full_o, 1);
        check("ovr_flag16", bus.overrun_o, 0);
      end
    end
    check("ovr_flag", bus.overrun_o, 1);
    check("ovr_full", bus.rx_full_o, 1);
    for (int i = 1; i <= 16; i++) begin
      check("ovr_data", bus.data_o, 32'(8'(8'h10 + i)));
      pop();
    end
    check("ovr_drained", bus.rx_empty_o, 1);
    check("ovr_sticky", bus.overrun_o, 1);
    clear_errs();
    check("ovr_cleared", bus.overrun_o, 0);

    // Glitch rejection, then a frame with a bad stop bit.
    tb_line = 1'b0;
    tick(1);
    tb_line = 1'b1;
    tick(40);
    check("glitch_no_frame", bus.rx_empty_o, 1);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    check("frm_pushed", bus.rx_empty_o, 0);
    check("frm_data", bus.data_o, 8'h3C);
    check("frm_flags", {bus.parity_error_o, bus.framing_error_o}, 2'b01);
    pop();
    check("frm_single", bus.rx_empty_o, 1);
    clear_errs();

    // Even parity with the wrong parity bit.
    bus.parity_bit_i  = 1'b1;
    bus.parity_even_i = 1'b1;
    send_frame(8'h01, 1'b1, 1'b0, 1'b1);
    check("par_data", bus.data_o, 8'h01);
    check("par_flags", {bus.parity_error_o, bus.framing_error_o}, 2'b10);
    pop();
    clear_errs();
    check("par_cleared", bus.parity_error_o, 0);

    // TX FIFO capacity right after reset, looped back at 4 clocks per bit.
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    bus.clock_divider_i = 16'd2;
    bus.parity_bit_i    = 1'b0;
    loop_en             = 1'b1;
    tick(2);
    for (int i = 0; i < 18; i++) push(8'(8'hA0 + i));
    check("txf_full", bus.tx_full_o, 1);
    check("txf_busy", bus.tx_busy_o, 1);
    for (int i = 0; i < 17; i++) begin
      wait_rx("txf_rx_wait");
      check("txf_rx_data", bus.data_o, 32'(8'(8'hA0 + i)));
      pop();
    end
    tick(200);
    check("txf_no_18th", bus.rx_empty_o, 1);
    check("txf_tx_empty", bus.tx_empty_o, 1);

    // Reset during data bit 3 of a 0x00 frame.
    bus.clock_divider_i = 16'd16;
    tick(2);
    push(8'h00);
    push(8'h00);
    wait_start("rmf_start");
    tick(72);
    check("rmf_pre_low", bus.serial_o, 0);
    #2 rst = 1'b1;
    #1;
    check("rmf_serial_async", bus.serial_o, 1);
    check("rmf_tx_empty", bus.tx_empty_o, 1);
    check("rmf_rx_empty", bus.rx_empty_o, 1);
    check("rmf_busy", bus.tx_busy_o, 0);
    @(negedge clk);
    rst = 1'b0;
    seen_low = 1'b0;
    for (int j = 0; j < 400; j++) begin
      @(negedge clk);
      if (bus.serial_o !== 1'b1) seen_low = 1'b1;
    end
    check("rmf_line_idle", seen_low, 0);
    check("rmf_rx_after", bus.rx_empty_o, 1);
    check("rmf_tx_after", bus.tx_empty_o, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
